uart_tx_feeder: RTL and testbench
=================================

Name: uart_tx_feeder

Overview:
- Upstream stage of uart_ip's transmitter: buffers bytes from the host side in a FIFO and drives uart_ip's start_tx/data_in, one byte per frame.
- Issues the next byte only after uart_ip reports tx_done.
- Removes the need for the host to poll the transmitter or hold start_tx/data_in itself.

Parameters:
- DEPTH, 16, FIFO entries; power of two, >= 2.
- AW, 4, log2(DEPTH); pointer width.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- uart_en  in  1  uart_ip enable; launching is gated by it.
- wr_en  in  1  host write strobe, one byte per cycle.
- wr_data  in  8  host byte.
- clr_ovf  in  1  clears the overflow flag.
- full  out  1  FIFO holds DEPTH bytes.
- empty  out  1  FIFO holds 0 bytes.
- level  out  AW+1  byte count, 0..DEPTH.
- overflow  out  1  sticky: a write was dropped.
- busy  out  1  FSM not in IDLE.
- start_tx  out  1  to uart_ip start_tx; single-cycle pulse.
- data_in  out  8  to uart_ip data_in; byte being sent.
- tx_done  in  1  from uart_ip; single-cycle pulse at end of stop bit.

Behaviour:
- Reset (resetn=0, asynchronous):
  - Pointers and level go to 0; empty=1, full=0.
  - overflow=0, start_tx=0, data_in=8'h00, FSM=IDLE, busy=0.
  - Applies at any time, including mid-frame. A byte already handed to uart_ip is abandoned.
- FIFO:
  - Registered write and read pointers, each AW+1 bits; the extra MSB is the wrap bit.
  - full = (ptr MSBs differ) and (low AW bits equal). empty = (pointers equal).
  - level = wr_ptr - rd_ptr, modulo 2^(AW+1).
  - Write is accepted when wr_en=1 and full=0 (full as seen at that edge).
- Overflow:
  - wr_en=1 while full=1 drops the byte and sets overflow.
  - Write while full with a pop on the same edge: the write is still rejected and overflow is set.
  - Clearing: clr_ovf=1 clears overflow. If a dropped write and clr_ovf occur on the same edge, set wins.
- Read (pop):
  - Occurs only on the IDLE->LAUNCH transition.
  - Pop and accepted write may occur on the same edge; level is unchanged in that case.
- FSM states: IDLE, LAUNCH, WAIT_DONE.
  - IDLE: if empty=0 and uart_en=1, pop the head byte, register it into data_in, go to LAUNCH.
  - LAUNCH: start_tx=1 for exactly this one cycle; go to WAIT_DONE.
  - WAIT_DONE:
    - tx_done=1: go to IDLE.
    - uart_en=0: go to IDLE; the byte is dropped, not re-queued.
    - Otherwise stay.
  - tx_done while in IDLE or LAUNCH is ignored.
- data_in stability:
  - data_in holds its value from LAUNCH until the next pop; it changes only on a pop.
- Latency:
  - Byte written at edge k into an empty FIFO with FSM in IDLE: FSM pops at edge k+1, and start_tx is high in the cycle after edge k+1.
  - Back-to-back frames: tx_done at edge m -> IDLE; pop at edge m+1; start_tx high in the cycle after edge m+1. The inter-frame gap is 2 clocks plus uart_ip's own overhead.
- busy = (state != IDLE).
- The FIFO storage array is not reset; only pointers, flags and outputs are.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding: IDLE=2'd0, LAUNCH=2'd1, WAIT_DONE=2'd2.
  - UART_DATA_W=8.
  - Baud select codes, shared with uart_ip.
- One sub-module: uart_sync_fifo (parameters DEPTH, AW, W=8). Provides push/pop/full/empty/level, is reusable later on the RX side, and is instantiated once here.
- The FSM, overflow flag and output registers stay in uart_tx_feeder.

Test Plan:
- Single byte: after reset, write 8'h5A with uart_en=1.
  - start_tx is a single 1-cycle pulse one cycle after the pop edge; data_in=8'h5A.
  - busy=1 until tx_done; level returns to 0.
- Burst: write 8'h01..8'h04 on consecutive cycles.
  - Exactly 4 start_tx pulses, each after the preceding tx_done; data_in sequence 01,02,03,04.
  - Pulse 2 rises 2 clocks after tx_done #1.
- Fill/overflow: uart_en=0; write 17 bytes (8'h10..8'h20).
  - full=1 and level=16 after the 16th write; the 17th write is dropped and overflow=1.
  - Enable uart_en: 8'h10..8'h1F are sent in order, never 8'h20.
  - Raise clr_ovf: overflow clears.
- Wrap and simultaneous events: push/pop 40 bytes with the FIFO kept partly full.
  - Order is preserved across pointer wrap; level is correct on cycles with a write and a pop on the same edge.
- Abort and reset mid-frame:
  - Deassert uart_en in WAIT_DONE: FSM returns to IDLE and no start_tx follows until uart_en=1; the byte is lost and level is unchanged.
  - Assert resetn=0 mid-burst: all outputs immediately show reset values, and no start_tx occurs until new writes arrive.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: data width, transmit-feeder FSM encoding, baud select codes.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_DONE = 2'd2
  } tx_state_e;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'd0,
    BAUD_19200  = 2'd1,
    BAUD_57600  = 2'd2,
    BAUD_115200 = 2'd3
  } baud_sel_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous show-ahead FIFO; push/pop take effect at the clock edge, head visible combinationally.
// Backpressure: push ignored when full, pop ignored when empty; caller owns overflow reporting.
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int AW    = 4,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         resetn,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic [AW:0]  level
);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic         push_ok;
  logic         pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Extra MSB on each pointer distinguishes full from empty when the low bits match.
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign level = wr_ptr - rd_ptr;

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers host bytes and hands them to uart_ip one frame at a time; start_tx one cycle after the pop edge.
// Host writes into a full FIFO are dropped and flagged on sticky overflow; next byte waits for tx_done.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   uart_en,
  input  logic                   wr_en,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   clr_ovf,
  output logic                   full,
  output logic                   empty,
  output logic [AW:0]            level,
  output logic                   overflow,
  output logic                   busy,
  output logic                   start_tx,
  output logic [UART_DATA_W-1:0] data_in,
  input  logic                   tx_done
);

  tx_state_e              state;
  tx_state_e              state_nxt;
  logic                   pop;
  logic [UART_DATA_W-1:0] head;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (UART_DATA_W)
  ) u_fifo (
    .clock     (clock),
    .resetn    (resetn),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .level     (level)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (!empty && uart_en) state_nxt = LAUNCH;
      LAUNCH:    state_nxt = WAIT_DONE;
      // Losing uart_en mid-frame abandons the byte rather than re-queuing it.
      WAIT_DONE: if (tx_done || !uart_en) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pop      = 1'b0;
    start_tx = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        pop  = !empty && uart_en;
      end
      LAUNCH:    start_tx = 1'b1;
      WAIT_DONE: start_tx = 1'b0;
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) data_in <= '0;
    else if (pop) data_in <= head;
  end

  // A dropped write on the same edge as clr_ovf keeps the flag set.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn)              overflow <= 1'b0;
    else if (wr_en && full)   overflow <= 1'b1;
    else if (clr_ovf)         overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder: stimulus queues expected bytes, a negedge monitor checks launches.
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clock = 1'b0;
  logic          resetn;
  logic          uart_en;
  logic          wr_en;
  logic [7:0]    wr_data;
  logic          clr_ovf;
  logic          tx_done;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          busy;
  logic          start_tx;
  logic [7:0]    data_in;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         n_starts = 0;
  int         n_pops = 0;
  int         n_wr = 0;
  int         frame_len = 3;
  bit         auto_done = 1'b0;
  bit         have_done = 1'b0;
  int         done_cycle = 0;
  bit         prev_start = 1'b0;
  logic [7:0] cur_byte = 8'h00;

  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .uart_en  (uart_en),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .clr_ovf  (clr_ovf),
    .full     (full),
    .empty    (empty),
    .level    (level),
    .overflow (overflow),
    .busy     (busy),
    .start_tx (start_tx),
    .data_in  (data_in),
    .tx_done  (tx_done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input bit acc);
    wr_en   = 1'b1;
    wr_data = b;
    if (acc) exp_q.push_back(b);
    tick();
    wr_en = 1'b0;
    if (acc) n_wr++;
  endtask

  task automatic wait_idle(input int limit);
    int i;
    for (i = 0; i < limit; i++) begin
      if (!busy && empty && exp_q.size() == 0) break;
      tick();
    end
    chk("idle_timeout", 32'(i < limit), 32'd1);
  endtask

  // uart_ip stand-in: answers each launch with a one-cycle tx_done after frame_len cycles.
  initial begin
    tx_done = 1'b0;
    forever begin
      @(negedge clock);
      if (resetn && start_tx && auto_done) begin
        repeat (frame_len) @(posedge clock);
        #1;
        if (resetn && auto_done) begin
          tx_done    = 1'b1;
          done_cycle = cyc;
          have_done  = 1'b1;
          @(posedge clock);
          #1;
          tx_done = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pop on each launch, plus level/empty against writes minus pops.
  always @(negedge clock) begin
    if (resetn) begin
      if (start_tx) begin
        n_starts++;
        n_pops++;
        chk("start_width", 32'(prev_start), 32'd0);
        chk("busy_in_launch", 32'(busy), 32'd1);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_start data_in=%0h required=none at cycle %0d", data_in, cyc);
        end else begin
          chk("data_in", 32'(data_in), 32'(exp_q.pop_front()));
        end
        if (have_done) begin
          chk("frame_gap", 32'(cyc - done_cycle), 32'd2);
          have_done = 1'b0;
        end
        cur_byte = data_in;
      end else if (busy) begin
        chk("data_hold", 32'(data_in), 32'(cur_byte));
      end
      chk("level", 32'(level), 32'(n_wr - n_pops));
      chk("empty", 32'(empty), 32'(n_wr == n_pops));
      prev_start = start_tx;
    end else begin
      prev_start = 1'b0;
    end
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    resetn  = 1'b0;
    uart_en = 1'b0;
    wr_en   = 1'b0;
    wr_data = 8'h00;
    clr_ovf = 1'b0;
    repeat (3) tick();
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start_tx", 32'(start_tx), 32'd0);
    chk("rst_data_in", 32'(data_in), 32'd0);
    resetn = 1'b1;
    tick();

    // Single byte
    uart_en   = 1'b1;
    frame_len = 3;
    auto_done = 1'b1;
    have_done = 1'b0;
    s0 = n_starts;
    wr(8'h5A, 1'b1);
    tick();
    chk("single_start", 32'(start_tx), 32'd1);
    chk("single_busy", 32'(busy), 32'd1);
    chk("single_data", 32'(data_in), 32'h5A);
    chk("single_level", 32'(level), 32'd0);
    tick();
    chk("single_pulse_end", 32'(start_tx), 32'd0);
    chk("single_busy_wait", 32'(busy), 32'd1);
    wait_idle(100);
    chk("single_count", 32'(n_starts - s0), 32'd1);

    // Burst of four; frame_gap checks run in the monitor
    have_done = 1'b0;
    s0 = n_starts;
    for (int i = 1; i <= 4; i++) wr(8'(i), 1'b1);
    wait_idle(200);
    chk("burst_count", 32'(n_starts - s0), 32'd4);

    // Fill and overflow
    uart_en   = 1'b0;
    have_done = 1'b0;
    for (int i = 0; i < 16; i++) wr(8'(8'h10 + i), 1'b1);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_no_ovf", 32'(overflow), 32'd0);
    wr(8'h20, 1'b0);
    chk("ovf_set", 32'(overflow), 32'd1);
    chk("ovf_level", 32'(level), 32'd16);
    clr_ovf = 1'b1;
    wr(8'h21, 1'b0);
    clr_ovf = 1'b0;
    chk("ovf_set_wins", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clear1", 32'(overflow), 32'd0);
    // Write while full on the same edge as the first pop: still rejected
    uart_en = 1'b1;
    wr(8'h22, 1'b0);
    chk("ovf_pop_edge", 32'(overflow), 32'd1);
    chk("ovf_pop_level", 32'(level), 32'd15);
    wait_idle(400);
    chk("ovf_sticky", 32'(overflow), 32'd1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    chk("ovf_clear2", 32'(overflow), 32'd0);

    // Wrap: writes every other cycle, faster than frames drain
    frame_len = 1;
    have_done = 1'b0;
    s0 = n_starts;
    for (int i = 0; i < 40; i++) begin
      wr(8'(8'h40 + i), 1'b1);
      tick();
    end
    wait_idle(400);
    chk("wrap_count", 32'(n_starts - s0), 32'd40);
    chk("wrap_no_ovf", 32'(overflow), 32'd0);

    // Abort in WAIT_DONE
    frame_len = 3;
    auto_done = 1'b0;
    have_done = 1'b0;
    s0 = n_starts;
    wr(8'hAA, 1'b1);
    tick();
    tick();
    chk("abort_waiting", 32'(busy), 32'd1);
    uart_en = 1'b0;
    tick();
    chk("abort_idle", 32'(busy), 32'd0);
    wr(8'hBB, 1'b1);
    repeat (5) tick();
    chk("abort_no_start", 32'(n_starts - s0), 32'd1);
    chk("abort_level", 32'(level), 32'd1);
    auto_done = 1'b1;
    uart_en   = 1'b1;
    wait_idle(100);
    chk("abort_resume", 32'(n_starts - s0), 32'd2);

    // Reset mid-burst
    have_done = 1'b0;
    s0 = n_starts;
    for (int i = 0; i < 4; i++) wr(8'(8'h61 + i), 1'b1);
    for (int i = 0; i < 100; i++) begin
      if (n_starts - s0 >= 2) break;
      tick();
    end
    chk("midburst_reached", 32'(n_starts - s0 >= 2), 32'd1);
    tick();
    resetn = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_start_tx", 32'(start_tx), 32'd0);
    chk("arst_data_in", 32'(data_in), 32'd0);
    chk("arst_level", 32'(level), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_overflow", 32'(overflow), 32'd0);
    exp_q.delete();
    n_wr   = 0;
    n_pops = 0;
    repeat (2) tick();
    resetn = 1'b1;
    s0 = n_starts;
    repeat (20) tick();
    chk("post_rst_quiet", 32'(n_starts - s0), 32'd0);
    have_done = 1'b0;
    wr(8'h77, 1'b1);
    wait_idle(100);
    chk("post_rst_send", 32'(n_starts - s0), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
